buf_cipher_adapter: RTL and testbench
=====================================

# buf_cipher_adapter

Block-level sequencer between the SD data-line driver's nibble buffer and the GOST block cipher core. After a 512-byte sector has been received into the 1024×4 buffer, it reads the sector 16 nibbles at a time, packs each group into a 64-bit block, and hands the block to the cipher. It then writes the cipher result back to the same 16 buffer locations. The driver can later transmit the processed sector from the buffer unchanged.

## Interface
- BLOCKS, 64, number of 64-bit blocks per run (64 = one 512-byte sector; legal range 1..64)
- iclk  in  1  system clock; all logic on rising edge
- irst  in  1  synchronous active-high reset
- istart  in  1  start a sector pass; one-cycle pulse, sampled only in IDLE
- obusy  out  1  high from the cycle after accepted istart until odone
- odone  out  1  one-cycle pulse when the last block has been written back
- oaddr  out  10  buffer address
- irdata  in  4  buffer read data, valid the cycle after oaddr (synchronous RAM)
- owdata  out  4  buffer write data
- owrite_en  out  1  buffer write strobe
- oblock  out  64  block to cipher; stable from ocipher_start until icipher_done
- ocipher_start  out  1  one-cycle pulse: oblock valid, start cipher
- iblock  in  64  cipher result, valid in the icipher_done cycle
- icipher_done  in  1  one-cycle pulse from cipher: iblock valid

## Operation
- States: IDLE, READ, START, WAIT, WRITE, DONE.
- IDLE: all strobes low. istart=1 → READ, block counter b=0, nibble counter j=0.
- READ: oaddr=16b+j for j=0..15, one address per cycle.
  - irdata captured one cycle later into oblock[63-4j -: 4]; the first nibble lands in the MSBs.
  - The capture of j=15 completes on the 17th READ cycle → START.
- START: ocipher_start=1 for exactly one cycle → WAIT.
- WAIT: hold oblock. icipher_done=1 latches iblock into an internal result register → WRITE, j=0.
- WRITE: owrite_en=1, oaddr=16b+j, owdata=result[63-4j -: 4] for j=0..15 (16 cycles).
  - After j=15: if b=BLOCKS-1 → DONE, else b=b+1 → READ.
- DONE: odone=1 for one cycle, obusy falls in the same cycle → IDLE.
- Counter widths: b is 6 bits, j is 4 bits. The address is {b,j}; it never exceeds 16·BLOCKS-1 and never wraps.
- istart while not IDLE: ignored, no restart.
- icipher_done outside WAIT, including the START cycle: ignored.
- irst at any time: state returns to IDLE next edge, counters are cleared, and no further buffer writes occur. A partially written block is left as-is.

## Timing
- Reset values: oaddr=0, owdata=0, owrite_en=0, oblock=0, ocipher_start=0, obusy=0, odone=0.
- istart at edge n → first read address on the bus in cycle n+1.
- Per block: 17 (READ) + 1 (START) + W (WAIT cycles until icipher_done, W≥1) + 16 (WRITE) cycles.
- Full pass with W=1: 64·35 + 1 (DONE) = 2241 cycles from the first READ cycle to the odone cycle.
- Buffer port: reads and writes never occur in the same cycle. owrite_en is high only in WRITE.
- Outputs are registered. oaddr is don't-care outside READ and WRITE but must hold its last value.

## Test plan
- Identity pass: buffer nibble a = a[3:0]; cipher model returns iblock=oblock after 1 cycle; BLOCKS=64.
  - Expect the first oblock = 64'h0123456789ABCDEF.
  - Expect 64 ocipher_start pulses, the buffer unchanged, odone exactly 2241 cycles after the first READ cycle.
- Inversion: cipher returns ~oblock after 5 cycles; BLOCKS=2.
  - Expect addresses 0..31 hold ~original and address 32 untouched.
  - Expect odone after 2·39+1 cycles.
- Busy restart: pulse istart during WAIT of block 0.
  - Expect no address reset, one odone only, ocipher_start count = BLOCKS.
- Spurious done: assert icipher_done during READ and in the START cycle.
  - Expect no state change and no write. The block proceeds only on a later icipher_done in WAIT.
- Reset mid-WRITE: irst at j=7 of block 3.
  - Expect nibbles 48..55 written and 56..63 unchanged.
  - Expect all outputs at reset values next cycle; a new istart begins at address 0.
- Back-to-back runs: istart in the cycle after odone.
  - Expect a second full pass to start at address 0 with identical timing.

Source files
------------

// File: rtl/buf_cipher_adapter.sv
// Sector sequencer between the SD nibble buffer and the GOST core: packs 16 nibbles
// per 64-bit block, runs the cipher, and writes the result back to the same locations.
module buf_cipher_adapter #(
  parameter int unsigned BLOCKS = 64
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  output logic        obusy,
  output logic        odone,
  output logic [9:0]  oaddr,
  input  logic [3:0]  irdata,
  output logic [3:0]  owdata,
  output logic        owrite_en,
  output logic [63:0] oblock,
  output logic        ocipher_start,
  input  logic [63:0] iblock,
  input  logic        icipher_done
);

  typedef enum logic [2:0] {IDLE, READ, START, WAIT, WRITE, DONE} state_t;

  localparam logic [5:0] LAST_BLK = 6'(BLOCKS - 1);

  state_t      state_q;
  logic [5:0]  b_q;
  logic [3:0]  j_q;
  logic        rd_valid_q;
  logic        rd_tail_q;
  logic [63:0] res_q;
  logic [9:0]  addr_q;
  logic [3:0]  wdata_q;
  logic        we_q;
  logic [63:0] blk_q;
  logic        cstart_q;
  logic        busy_q;
  logic        done_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q    <= IDLE;
      b_q        <= '0;
      j_q        <= '0;
      rd_valid_q <= 1'b0;
      rd_tail_q  <= 1'b0;
      res_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      blk_q      <= '0;
      cstart_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (istart) begin
            state_q    <= READ;
            busy_q     <= 1'b1;
            b_q        <= '0;
            j_q        <= '0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_tail_q  <= 1'b0;
          end
        end
        READ: begin
          // Data trails the address by one cycle: the block fills MSB-first and
          // completes one cycle after the j=15 address has been issued.
          if (rd_valid_q) blk_q <= {blk_q[59:0], irdata};
          rd_valid_q <= 1'b1;
          if (rd_tail_q) begin
            state_q  <= START;
            cstart_q <= 1'b1;
          end else if (j_q == 4'd15) begin
            rd_tail_q <= 1'b1;
          end else begin
            j_q    <= j_q + 4'd1;
            addr_q <= {b_q, j_q + 4'd1};
          end
        end
        START: begin
          cstart_q <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (icipher_done) begin
            state_q <= WRITE;
            j_q     <= '0;
            addr_q  <= {b_q, 4'd0};
            wdata_q <= iblock[63:60];
            res_q   <= {iblock[59:0], 4'h0};
            we_q    <= 1'b1;
          end
        end
        WRITE: begin
          if (j_q == 4'd15) begin
            we_q <= 1'b0;
            if (b_q == LAST_BLK) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= READ;
              b_q        <= b_q + 6'd1;
              j_q        <= '0;
              addr_q     <= {b_q + 6'd1, 4'd0};
              rd_valid_q <= 1'b0;
              rd_tail_q  <= 1'b0;
            end
          end else begin
            j_q     <= j_q + 4'd1;
            addr_q  <= {b_q, j_q + 4'd1};
            wdata_q <= res_q[63:60];
            res_q   <= {res_q[59:0], 4'h0};
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign obusy         = busy_q;
  assign odone         = done_q;
  assign oaddr         = addr_q;
  assign owdata        = wdata_q;
  assign owrite_en     = we_q;
  assign oblock        = blk_q;
  assign ocipher_start = cstart_q;

endmodule

// File: tb/tb_buf_cipher_adapter.sv
// Bench for buf_cipher_adapter: buffer RAM and cipher models, block/write scoreboard,
// directed passes on a 64-block instance and a 2-block instance.
module tb_buf_cipher_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] patt(input int a);
    return 4'((a * 7) + (a >> 4) + 3);
  endfunction

  // ---------------- 64-block instance ----------------
  logic        rst, start, busy, done, we, cstart, spur, cdone_m, cdone;
  logic [9:0]  addr;
  logic [3:0]  rdata, wdata;
  logic [63:0] blk, iblk_m, iblk;
  logic        init_go, init_ident;
  logic [3:0]  mem [1024];
  logic        cinv = 1'b0;
  int          clat = 1;
  int          ccnt = 0;

  assign cdone = cdone_m | spur;
  assign iblk  = spur ? 64'hDEAD_BEEF_0BAD_F00D : iblk_m;

  buf_cipher_adapter #(.BLOCKS(64)) u_dut (
    .iclk(clk), .irst(rst), .istart(start), .obusy(busy), .odone(done),
    .oaddr(addr), .irdata(rdata), .owdata(wdata), .owrite_en(we),
    .oblock(blk), .ocipher_start(cstart), .iblock(iblk), .icipher_done(cdone)
  );

  always @(posedge clk) begin
    if (init_go) begin
      for (int a = 0; a < 1024; a++) mem[a] <= init_ident ? 4'(a) : patt(a);
    end else begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

  always @(posedge clk) begin
    cdone_m <= 1'b0;
    if (ccnt != 0) begin
      ccnt <= ccnt - 1;
      if (ccnt == 1) begin
        cdone_m <= 1'b1;
        iblk_m  <= cinv ? ~blk : blk;
      end
    end
    if (cstart) begin
      if (clat == 1) begin
        cdone_m <= 1'b1;
        iblk_m  <= cinv ? ~blk : blk;
      end else begin
        ccnt <= clat - 1;
      end
    end
  end

  logic [63:0] exp_blk_q [$];
  logic [13:0] exp_wr_q [$];
  logic [13:0] e_wr;
  logic [63:0] first_blk;
  int n_cs = 0;
  int n_dn = 0;

  always @(negedge clk) begin
    if (cstart) begin
      if (n_cs == 0) first_blk = blk;
      n_cs++;
      chk("cstart_pending", 64'(exp_blk_q.size() != 0), 64'd1);
      if (exp_blk_q.size() != 0) chk("oblock", blk, exp_blk_q.pop_front());
    end
    if (we) begin
      chk("write_pending", 64'(exp_wr_q.size() != 0), 64'd1);
      if (exp_wr_q.size() != 0) begin
        e_wr = exp_wr_q.pop_front();
        chk("write_addr", 64'(addr), 64'(e_wr[13:4]));
        chk("write_data", 64'(wdata), 64'(e_wr[3:0]));
      end
    end
    if (done) n_dn++;
  end

  task automatic load_mem(input logic ident);
    init_ident = ident;
    init_go = 1'b1;
    @(negedge clk);
    init_go = 1'b0;
  endtask

  task automatic push_pass();
    logic [63:0] eb, r;
    for (int b = 0; b < 64; b++) begin
      eb = '0;
      for (int j = 0; j < 16; j++) eb = {eb[59:0], mem[16*b+j]};
      exp_blk_q.push_back(eb);
      r = cinv ? ~eb : eb;
      for (int j = 0; j < 16; j++) exp_wr_q.push_back({10'(16*b+j), r[63-4*j -: 4]});
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first READ cycle.
  task automatic begin_pass(output int t0);
    push_pass();
    n_cs = 0;
    n_dn = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk("first_read_addr", 64'(addr), 64'd0);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Returns at the negedge of the cycle following odone.
  task automatic end_pass(input string p, input int t0, input int cycles);
    int k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({p, "_done_seen"}, 64'(done), 64'd1);
    chk({p, "_busy_low_in_done"}, 64'(busy), 64'd0);
    chk({p, "_cycles"}, 64'(cyc - t0 + 1), 64'(cycles));
    @(negedge clk);
    chk({p, "_done_count"}, 64'(n_dn), 64'd1);
    chk({p, "_cstart_count"}, 64'(n_cs), 64'd64);
    chk({p, "_blk_queue_empty"}, 64'(exp_blk_q.size()), 64'd0);
    chk({p, "_wr_queue_empty"}, 64'(exp_wr_q.size()), 64'd0);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_oaddr"}, 64'(addr), 64'd0);
    chk({p, "_owdata"}, 64'(wdata), 64'd0);
    chk({p, "_owrite_en"}, 64'(we), 64'd0);
    chk({p, "_oblock"}, blk, 64'd0);
    chk({p, "_ocipher_start"}, 64'(cstart), 64'd0);
    chk({p, "_obusy"}, 64'(busy), 64'd0);
    chk({p, "_odone"}, 64'(done), 64'd0);
  endtask

  // ---------------- 2-block instance: inversion, 5-cycle cipher ----------------
  logic        b_start, b_busy, b_done, b_we, b_cstart, b_cdone = 1'b0, b_init;
  logic [9:0]  b_addr;
  logic [3:0]  b_rdata, b_wdata;
  logic [63:0] b_blk, b_iblk;
  logic [3:0]  mem2 [1024];
  int          b_cnt = 0;

  buf_cipher_adapter #(.BLOCKS(2)) u_dut2 (
    .iclk(clk), .irst(rst), .istart(b_start), .obusy(b_busy), .odone(b_done),
    .oaddr(b_addr), .irdata(b_rdata), .owdata(b_wdata), .owrite_en(b_we),
    .oblock(b_blk), .ocipher_start(b_cstart), .iblock(b_iblk), .icipher_done(b_cdone)
  );

  always @(posedge clk) begin
    if (b_init) begin
      for (int a = 0; a < 1024; a++) mem2[a] <= patt(a);
    end else begin
      b_rdata <= mem2[b_addr];
      if (b_we) mem2[b_addr] <= b_wdata;
    end
  end

  always @(posedge clk) begin
    b_cdone <= 1'b0;
    if (b_cnt != 0) begin
      b_cnt <= b_cnt - 1;
      if (b_cnt == 1) begin
        b_cdone <= 1'b1;
        b_iblk  <= ~b_blk;
      end
    end
    if (b_cstart) b_cnt <= 4;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t0, k;
    rst = 1'b1; start = 1'b0; spur = 1'b0; init_go = 1'b0; init_ident = 1'b0;
    b_start = 1'b0; b_init = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // Inversion on BLOCKS=2: 2*39+1 cycles, words 0..31 inverted, 32 untouched
    b_init = 1'b1;
    @(negedge clk);
    b_init = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    t0 = cyc;
    chk("inv_first_addr", 64'(b_addr), 64'd0);
    k = 0;
    while (!b_done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("inv_done_seen", 64'(b_done), 64'd1);
    chk("inv_cycles", 64'(cyc - t0 + 1), 64'd79);
    @(negedge clk);
    chk("inv_busy_idle", 64'(b_busy), 64'd0);
    for (int a = 0; a < 32; a++) chk("inv_word", 64'(mem2[a]), 64'(patt(a) ^ 4'hF));
    chk("inv_word32_untouched", 64'(mem2[32]), 64'(patt(32)));

    // Identity pass, 1-cycle cipher
    load_mem(1'b1);
    cinv = 1'b0; clat = 1;
    begin_pass(t0);
    end_pass("ident", t0, 2241);
    chk("ident_first_oblock", first_blk, 64'h0123456789ABCDEF);
    for (int a = 0; a < 1024; a++) chk("ident_unchanged", 64'(mem[a]), 64'(a & 15));

    // istart during WAIT of block 0 is ignored
    clat = 3;
    begin_pass(t0);
    k = 0;
    while (!cstart && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("restart_cstart_seen", 64'(cstart), 64'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy_held", 64'(busy), 64'd1);
    end_pass("restart", t0, 64 * 37 + 1);

    // Spurious icipher_done in READ and START
    clat = 4;
    begin_pass(t0);
    repeat (2) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_read_no_write", 64'(we), 64'd0);
    k = 0;
    while (!cstart && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("spur_cstart_cycle", 64'(cyc - t0), 64'd17);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_start_no_write", 64'(we), 64'd0);
    k = 0;
    while (!we && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("spur_first_write_cycle", 64'(cyc - t0), 64'd22);
    end_pass("spur", t0, 64 * 38 + 1);

    // Reset during WRITE j=7 of block 3
    load_mem(1'b0);
    cinv = 1'b1; clat = 1;
    begin_pass(t0);
    k = 0;
    while (!(we && addr == 10'd55) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_j7", 64'(addr), 64'd55);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    exp_blk_q.delete();
    exp_wr_q.delete();
    for (int a = 0; a < 56; a++) chk("rst_written", 64'(mem[a]), 64'(patt(a) ^ 4'hF));
    for (int a = 56; a < 64; a++) chk("rst_unwritten", 64'(mem[a]), 64'(patt(a)));

    // Fresh start after reset, then back-to-back pass
    cinv = 1'b0; clat = 1;
    begin_pass(t0);
    end_pass("post_rst", t0, 2241);
    begin_pass(t0);
    end_pass("b2b", t0, 2241);
    for (int a = 0; a < 1024; a++)
      chk("final_mem", 64'(mem[a]), 64'((a < 56) ? (patt(a) ^ 4'hF) : patt(a)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
